// File: rtl/sqrt_sched_pkg.sv
// Shared types for the sqrt formula scheduler: slot/engine state encodings,
// the argument triplet and the rounded integer square root used by every engine.
package sqrt_sched_pkg;

    localparam int MAX_WORKERS = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} slot_state_t;

    typedef enum logic [1:0] {ENG_IDLE, ENG_S1, ENG_S2, ENG_S3} eng_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } arg_triplet_t;

    // Square root rounded to the nearest integer: bitwise floor root, then
    // round up when x exceeds r*r + r (i.e. lies past (r + 0.5)^2).
    function automatic logic [16:0] isqrt_round(input logic [32:0] x);
        logic [16:0] r;
        logic [16:0] t;
        logic [33:0] sq;
        r = '0;
        for (int i = 16; i >= 0; i--) begin
            t = r | (17'd1 << i);
            if (({17'd0, t} * {17'd0, t}) <= {1'b0, x}) r = t;
        end
        sq = {17'd0, r} * {17'd0, r};
        if (({1'b0, x} - sq) > {17'd0, r}) r = r + 17'd1;
        return r;
    endfunction

endpackage

// File: rtl/sqrt_sched_slot.sv
// One scheduler slot (IDLE/ISSUE/BUSY/DONE FSM, argument and result registers)
// and the three-step formula engines it can host. Engine latency is 3 cycles.
module formula_1_impl_1_top
    import sqrt_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    output logic [31:0] res
);
    eng_state_t  state;
    logic [31:0] ra, rb, rc, acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ENG_IDLE;
            ra      <= '0;
            rb      <= '0;
            rc      <= '0;
            acc     <= '0;
            res     <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            case (state)
                ENG_IDLE: if (arg_vld) begin
                    ra    <= a;
                    rb    <= b;
                    rc    <= c;
                    state <= ENG_S1;
                end
                ENG_S1: begin
                    acc   <= {15'd0, isqrt_round({1'b0, ra})};
                    state <= ENG_S2;
                end
                ENG_S2: begin
                    acc   <= acc + {15'd0, isqrt_round({1'b0, rb})};
                    state <= ENG_S3;
                end
                default: begin
                    res     <= acc + {15'd0, isqrt_round({1'b0, rc})};
                    res_vld <= 1'b1;
                    state   <= ENG_IDLE;
                end
            endcase
        end
    end
endmodule

// Same result as impl 1: all three roots in parallel, then two additions.
module formula_1_impl_2_top
    import sqrt_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    output logic [31:0] res
);
    eng_state_t  state;
    logic [31:0] ra, rb, rc, acc;
    logic [16:0] qa, qb, qc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ENG_IDLE;
            ra      <= '0;
            rb      <= '0;
            rc      <= '0;
            qa      <= '0;
            qb      <= '0;
            qc      <= '0;
            acc     <= '0;
            res     <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            case (state)
                ENG_IDLE: if (arg_vld) begin
                    ra    <= a;
                    rb    <= b;
                    rc    <= c;
                    state <= ENG_S1;
                end
                ENG_S1: begin
                    qa    <= isqrt_round({1'b0, ra});
                    qb    <= isqrt_round({1'b0, rb});
                    qc    <= isqrt_round({1'b0, rc});
                    state <= ENG_S2;
                end
                ENG_S2: begin
                    acc   <= {15'd0, qa} + {15'd0, qb};
                    state <= ENG_S3;
                end
                default: begin
                    res     <= acc + {15'd0, qc};
                    res_vld <= 1'b1;
                    state   <= ENG_IDLE;
                end
            endcase
        end
    end
endmodule

// Nested form: root(a + root(b + root(c))).
module formula_2_top
    import sqrt_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    output logic [31:0] res
);
    eng_state_t  state;
    logic [31:0] ra, rb, rc, acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ENG_IDLE;
            ra      <= '0;
            rb      <= '0;
            rc      <= '0;
            acc     <= '0;
            res     <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            case (state)
                ENG_IDLE: if (arg_vld) begin
                    ra    <= a;
                    rb    <= b;
                    rc    <= c;
                    state <= ENG_S1;
                end
                ENG_S1: begin
                    acc   <= {15'd0, isqrt_round({1'b0, rc})};
                    state <= ENG_S2;
                end
                ENG_S2: begin
                    acc   <= {15'd0, isqrt_round({1'b0, rb} + {1'b0, acc})};
                    state <= ENG_S3;
                end
                default: begin
                    res     <= {15'd0, isqrt_round({1'b0, ra} + {1'b0, acc})};
                    res_vld <= 1'b1;
                    state   <= ENG_IDLE;
                end
            endcase
        end
    end
endmodule

module sqrt_sched_slot
    import sqrt_sched_pkg::*;
#(
    parameter int formula = 1,
    parameter int impl    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dispatch,
    input  arg_triplet_t args,
    input  logic         retire,
    output slot_state_t  state,
    output logic [31:0]  res
);
    arg_triplet_t args_q;
    logic         eng_arg_vld;
    logic         eng_res_vld;
    logic [31:0]  eng_res;

    assign eng_arg_vld = (state == ISSUE);

    // Engine result strobes outside BUSY are dropped by the case below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            args_q <= '0;
            res    <= '0;
        end else begin
            case (state)
                IDLE: if (dispatch) begin
                    args_q <= args;
                    state  <= ISSUE;
                end
                ISSUE: state <= BUSY;
                BUSY: if (eng_res_vld) begin
                    res   <= eng_res;
                    state <= DONE;
                end
                default: if (retire) state <= IDLE;
            endcase
        end
    end

    if (formula == 2) begin : g_f2
        formula_2_top u_eng (
            .clk(clk), .rst(rst), .arg_vld(eng_arg_vld),
            .a(args_q.a), .b(args_q.b), .c(args_q.c),
            .res_vld(eng_res_vld), .res(eng_res)
        );
    end else if (impl == 2) begin : g_f1_i2
        formula_1_impl_2_top u_eng (
            .clk(clk), .rst(rst), .arg_vld(eng_arg_vld),
            .a(args_q.a), .b(args_q.b), .c(args_q.c),
            .res_vld(eng_res_vld), .res(eng_res)
        );
    end else begin : g_f1_i1
        formula_1_impl_1_top u_eng (
            .clk(clk), .rst(rst), .arg_vld(eng_arg_vld),
            .a(args_q.a), .b(args_q.b), .c(args_q.c),
            .res_vld(eng_res_vld), .res(eng_res)
        );
    end
endmodule

// File: rtl/sqrt_formula_scheduler.sv
// Round-robin in-order scheduler over N_WORKERS sqrt formula slots.
// Optional SQRT_SCHED_PERF_CNT_EN adds saturating perf_* counter outputs.
module sqrt_formula_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int N_WORKERS = 4,
    parameter int formula   = 1,
    parameter int impl      = 1,
    localparam int PTR_W    = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1,
    localparam int CNT_W    = $clog2(N_WORKERS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    output logic             arg_rdy,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [31:0]      c,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [31:0]      res,
    output logic [CNT_W-1:0] busy_cnt
`ifdef SQRT_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]      perf_accepted,
    output logic [31:0]      perf_in_stall,
    output logic [31:0]      perf_out_stall
`endif
);
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // arg_rdy and res_vld decode registered slot state only, so neither
    // depends on arg_vld or res_rdy in the same cycle.
    slot_state_t  st       [N_WORKERS];
    logic [31:0]  slot_res [N_WORKERS];
    arg_triplet_t args;
    logic [PTR_W-1:0] issue_ptr, retire_ptr;
    logic accept, retire;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_WORKERS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign args    = {a, b, c};
    assign arg_rdy = (st[issue_ptr] == IDLE);
    assign res_vld = (st[retire_ptr] == DONE);
    assign res     = res_vld ? slot_res[retire_ptr] : '0;
    assign accept  = arg_vld && arg_rdy;
    assign retire  = res_vld && res_rdy;

    for (genvar i = 0; i < N_WORKERS; i++) begin : g_slot
        sqrt_sched_slot #(.formula(formula), .impl(impl)) u_slot (
            .clk(clk),
            .rst(rst),
            .dispatch(accept && (issue_ptr == PTR_W'(i))),
            .args(args),
            .retire(retire && (retire_ptr == PTR_W'(i))),
            .state(st[i]),
            .res(slot_res[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_ptr  <= '0;
            retire_ptr <= '0;
        end else begin
            if (accept) issue_ptr <= ptr_next(issue_ptr);
            if (retire) retire_ptr <= ptr_next(retire_ptr);
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < N_WORKERS; i++) begin
            if (st[i] != IDLE) busy_cnt = busy_cnt + CNT_W'(1);
        end
    end

`ifdef SQRT_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_accepted  <= '0;
            perf_in_stall  <= '0;
            perf_out_stall <= '0;
        end else begin
            if (accept && (perf_accepted != '1))
                perf_accepted <= perf_accepted + 32'd1;
            if (arg_vld && !arg_rdy && (perf_in_stall != '1))
                perf_in_stall <= perf_in_stall + 32'd1;
            if (res_vld && !res_rdy && (perf_out_stall != '1))
                perf_out_stall <= perf_out_stall + 32'd1;
        end
    end
`endif

endmodule
